nibble_cmp_seq: RTL and testbench

NIBBLE_CMP_SEQ -- requirements
Module: nibble_cmp_seq

---
 rtl/nibble_cmp_seq_pkg.sv | 21 ++
 rtl/nibble_cmp_seq_cmp4.sv | 20 ++
 rtl/nibble_cmp_seq.sv | 125 ++++++++++++
 tb/tb_nibble_cmp_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_cmp_seq_pkg.sv
// Shared definitions for the nibble-serial magnitude comparator.
//   state_e : controller states (IDLE / CMP / HOLD)
//   res_e   : 2-bit compare result encoding (EQ=00, GT=01, LT=10)
//   SLICE_W : width of the single time-shared comparator slice
package nibble_cmp_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RES_EQ = 2'b00,
    RES_GT = 2'b01,
    RES_LT = 2'b10
  } res_e;

endpackage

// File: rtl/nibble_cmp_seq_cmp4.sv
// Combinational unsigned magnitude comparator for one 4-bit slice.
//   x, y : slice operands
//   gt   : x > y
//   eq   : x == y
//   lt   : x < y
module cmp4_slice
  import nibble_cmp_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  output logic               gt,
  output logic               eq,
  output logic               lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/nibble_cmp_seq.sv
// Nibble-serial unsigned comparator. Latches an operand pair, then walks the
// nibbles from MSB down through one shared 4-bit slice, stopping at the first
// unequal nibble (or at nibble 0). The result is held until the consumer
// takes it.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b sampled on accept)
//   out_valid/out_ready : result handshake
//   a_gt_b/a_eq_b/a_lt_b: one-hot result, all 0 when out_valid=0
//   steps               : number of slice compares used (1..NIBBLES)
module nibble_cmp_seq
  import nibble_cmp_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_lt_b,
  output logic [3:0]   steps
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e        state_q, state_d;
  res_e          res_q, res_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    steps_q, steps_d;
  logic          rdy_q, rdy_d;

  logic [NIBBLES-1:0][SLICE_W-1:0] a_nib, b_nib;
  logic s_gt, s_eq, s_lt;

  assign a_nib = a_q;
  assign b_nib = b_q;

  cmp4_slice u_slice (
    .x  (a_nib[idx_q]),
    .y  (b_nib[idx_q]),
    .gt (s_gt),
    .eq (s_eq),
    .lt (s_lt)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    steps_d = steps_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IW'(NIBBLES - 1);
          steps_d = 4'd0;
          state_d = CMP;
        end
      end
      CMP: begin
        steps_d = steps_q + 4'd1;
        if (!s_eq) begin
          // s_lt is implied when neither gt nor eq
          res_d   = s_gt ? RES_GT : RES_LT;
          state_d = HOLD;
        end else if (idx_q == '0) begin
          // mandatory exit at the last nibble; index never wraps
          res_d   = RES_EQ;
          state_d = HOLD;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so it drops during reset and rises on the first edge after
    // release; otherwise it tracks state==IDLE exactly.
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= RES_EQ;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      steps_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      steps_q <= steps_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == HOLD);
  assign a_gt_b    = out_valid && (res_q == RES_GT);
  assign a_eq_b    = out_valid && (res_q == RES_EQ);
  assign a_lt_b    = out_valid && (res_q == RES_LT);
  assign steps     = steps_q;

  // s_lt is kept on the slice interface; consumed here to document intent.
  logic unused_lt;
  assign unused_lt = s_lt;

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Self-checking bench for nibble_cmp_seq (NIBBLES=4): directed table,
// hand-written handshake/reset sequences, and randomized pairs against a
// behavioural reference.
module tb_nibble_cmp_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic         a_gt_b, a_eq_b, a_lt_b;
  logic [3:0]   steps;

  int n_cmp = 0;
  int n_err = 0;

  nibble_cmp_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_gt_b    (a_gt_b),
    .a_eq_b    (a_eq_b),
    .a_lt_b    (a_lt_b),
    .steps     (steps)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   res;    // {gt, eq, lt}
    logic [3:0]   steps;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every sample point goes through here so the flag invariant is checked
  // on every cycle the bench observes.
  task automatic tick();
    @(negedge clk);
    if (!rst)
      chk("flags_onehot", 32'($countones({a_gt_b, a_eq_b, a_lt_b})), out_valid ? 32'd1 : 32'd0);
  endtask

  // Reference: plain unsigned compare, steps from counting equal leading nibbles.
  function automatic void ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [2:0] res, output logic [3:0] st);
    int eqlead = 0;
    res = {x > y, x == y, x < y};
    for (int i = N - 1; i >= 0; i--) begin
      if (((x >> (4 * i)) & 16'hF) == ((y >> (4 * i)) & 16'hF)) eqlead++;
      else break;
    end
    st = 4'((eqlead + 1 > N) ? N : eqlead + 1);
  endfunction

  // One full transaction: offer, accept, measure latency, check, drain.
  task automatic do_txn(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [2:0] eres, input logic [3:0] esteps);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    a = xa;
    b = xb;
    tick();                         // accept edge passed
    in_valid = 1'b0;
    a = W'($urandom);               // must not disturb the result in flight
    b = W'($urandom);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_latency"}, 32'(lat), 32'(esteps));
    chk({tag, "_result"}, 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(eres));
    chk({tag, "_steps"}, 32'(steps), 32'(esteps));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    logic [2:0] r;
    logic [3:0] s;
    logic [W-1:0] ra, rb;
    int stable_bad;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_state", 32'({in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, steps}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ready_after_release", 32'(in_ready), 32'd1);

    // ---- directed table ----
    vecs.push_back('{16'h1234, 16'h0234, 3'b100, 4'd1});
    vecs.push_back('{16'hABCD, 16'hABCE, 3'b001, 4'd4});
    vecs.push_back('{16'h7777, 16'h7777, 3'b010, 4'd4});
    vecs.push_back('{16'h1234, 16'h1244, 3'b001, 4'd3});
    vecs.push_back('{16'h1200, 16'h1300, 3'b001, 4'd2});
    vecs.push_back('{16'h00FF, 16'h00FE, 3'b100, 4'd4});
    vecs.push_back('{16'h0000, 16'h0001, 3'b001, 4'd4});
    vecs.push_back('{16'hF000, 16'h0FFF, 3'b100, 4'd1});
    for (int i = 0; i < vecs.size(); i++)
      do_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].steps);

    // ---- equal operands held in HOLD with out_ready low ----
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 20) begin tick(); seen++; end
    chk("hold_latency", 32'(seen), 32'd4);
    stable_bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!(out_valid && a_eq_b && !a_gt_b && !a_lt_b && steps == 4'd4 && !in_ready))
        stable_bad++;
      tick();
    end
    chk("hold_stable", 32'(stable_bad), 32'd0);
    chk("hold_still_valid", 32'({out_valid, in_ready}), 32'b10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release_ready", 32'({out_valid, in_ready}), 32'b01);

    // ---- reset during the second CMP cycle ----
    in_valid = 1'b1; a = 16'h5A00; b = 16'h5B00;
    tick();                         // accept
    in_valid = 1'b0;
    tick();                         // first CMP edge done, now in 2nd CMP cycle
    rst = 1'b1;
    #1;
    chk("abort_immediate", 32'({in_ready, out_valid, steps}), 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    do_txn("after_abort", 16'h0001, 16'h0000, 3'b100, 4'd4);

    // ---- back-to-back with in_valid and out_ready held high ----
    in_valid = 1'b1; out_ready = 1'b1; a = 16'h8000; b = 16'h7FFF;
    tick();                         // accept first pair
    a = 16'h0000; b = 16'h0000;     // offered while busy: must wait
    tick();
    chk("b2b_first", 32'({out_valid, a_gt_b, a_eq_b, a_lt_b, steps}), {27'd0, 1'b1, 3'b100, 4'd1});
    tick();                         // HOLD exit edge
    chk("b2b_bubble", 32'({out_valid, in_ready}), 32'b01);
    tick();                         // second accept edge
    in_valid = 1'b0;
    chk("b2b_accepted", 32'(in_ready), 32'd0);
    seen = 0;
    while (!out_valid && seen < 20) begin tick(); seen++; end
    chk("b2b_latency", 32'(seen), 32'd4);
    chk("b2b_second", 32'({a_gt_b, a_eq_b, a_lt_b, steps}), {25'd0, 3'b010, 4'd4});
    tick();
    out_ready = 1'b0;
    chk("b2b_drained", 32'({out_valid, in_ready}), 32'b01);

    // ---- randomized pairs ----
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = W'($urandom);
        1: rb = ra;
        2: rb = ra ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
        default: rb = ra ^ W'($urandom_range(1, 255));
      endcase
      ref_cmp(ra, rb, r, s);
      do_txn("rand", ra, rb, r, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
